// File: rtl/mkr_par_rx.sv
// Receive side of the SAM D21 -> FPGA parallel byte link: synchronises and deglitches
// the strobe, captures the byte with a four-phase ACK, and buffers it one-deep for fabric.
module mkr_par_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  input  logic [DATA_W-1:0] iMKR_DATA,
  input  logic              iMKR_STB,
  output logic              oMKR_ACK,
  output logic [DATA_W-1:0] oDATA,
  output logic              oVALID,
  input  logic              iREADY,
  output logic              oBUSY,
  output logic              oERR_TIMEOUT,
  input  logic              iERR_CLR,
  output logic [15:0]       oBYTE_CNT
);

  localparam int QW = $clog2(GLITCH_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [QW-1:0] qMax  = QW'(GLITCH_CYC);
  localparam logic [TW-1:0] tLast = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {stIdle, stQual, stAck, stDrain} rxState_t;

  rxState_t state, stateNext;

  logic [SYNC_STAGES-1:0]             stbSync;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] dataSync;
  logic                               stbS;
  logic [DATA_W-1:0]                  dataS;

  logic [QW-1:0] qCnt, qCntNext, qInc;
  logic [TW-1:0] tCnt, tCntNext;
  logic          ackNext;
  logic          capture;
  logic          errSet;
  logic          bufFree;

  // NOTE: synchroniser flops are reset like any other state so the strobe
  // cannot look asserted out of reset.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      stbSync  <= '0;
      dataSync <= '0;
    end else begin
      // NOTE: non-blocking so every stage shifts from its pre-edge value.
      stbSync  <= {stbSync[SYNC_STAGES-2:0], iMKR_STB};
      dataSync <= {dataSync[SYNC_STAGES-2:0], iMKR_DATA};
    end
  end

  assign stbS    = stbSync[SYNC_STAGES-1];
  assign dataS   = dataSync[SYNC_STAGES-1];
  assign bufFree = !oVALID || iREADY;
  assign qInc    = (qCnt == qMax) ? qMax : qCnt + QW'(1);

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    stateNext = state;
    qCntNext  = qCnt;
    tCntNext  = tCnt;
    ackNext   = oMKR_ACK;
    capture   = 1'b0;
    errSet    = 1'b0;

    case (state)
      stIdle: begin
        if (stbS) begin
          if (GLITCH_CYC == 1 && bufFree) begin
            capture = 1'b1;
          end else begin
            stateNext = stQual;
            qCntNext  = QW'(1);
          end
        end
      end
      stQual: begin
        if (!stbS) begin
          stateNext = stIdle;
          qCntNext  = '0;
        end else begin
          qCntNext = qInc;
          // A qualified strobe waits here while the buffer is full: no ACK is backpressure.
          if (qInc == qMax && bufFree) capture = 1'b1;
        end
      end
      stAck: begin
        if (!stbS) begin
          ackNext   = 1'b0;
          stateNext = stIdle;
        end else if (tCnt == tLast) begin
          errSet    = 1'b1;
          ackNext   = 1'b0;
          stateNext = stDrain;
        end else begin
          tCntNext = tCnt + TW'(1);
        end
      end
      stDrain: begin
        // The stale strobe must fall before a new byte is considered.
        if (!stbS) stateNext = stIdle;
      end
      default: stateNext = stIdle;
    endcase

    if (capture) begin
      stateNext = stAck;
      ackNext   = 1'b1;
      tCntNext  = '0;
      qCntNext  = '0;
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state        <= stIdle;
      qCnt         <= '0;
      tCnt         <= '0;
      oMKR_ACK     <= 1'b0;
      oDATA        <= '0;
      oVALID       <= 1'b0;
      oBYTE_CNT    <= '0;
      oERR_TIMEOUT <= 1'b0;
    end else begin
      state    <= stateNext;
      qCnt     <= qCntNext;
      tCnt     <= tCntNext;
      oMKR_ACK <= ackNext;

      if (capture) begin
        oDATA     <= dataS;
        oVALID    <= 1'b1;
        oBYTE_CNT <= oBYTE_CNT + 16'd1;
      end else if (oVALID && iREADY) begin
        oVALID <= 1'b0;
      end

      if (errSet)        oERR_TIMEOUT <= 1'b1;
      else if (iERR_CLR) oERR_TIMEOUT <= 1'b0;
    end
  end

  assign oBUSY = (state != stIdle);

endmodule

// File: tb/tb_mkr_par_rx.sv
// Directed bench for mkr_par_rx: stimulus pushes expected bytes into a queue and a
// monitor pops and compares them whenever fabric consumes oDATA.
module tb_mkr_par_rx;

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  mkrData;
  logic        mkrStb;
  logic        mkrAck;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic        busy;
  logic        errTimeout;
  logic        errClr;
  logic [15:0] byteCnt;

  int total = 0;
  int bad   = 0;
  logic [7:0] expQ[$];

  mkr_par_rx dut (
    .iCLK        (clk),
    .iRESETn     (rstN),
    .iMKR_DATA   (mkrData),
    .iMKR_STB    (mkrStb),
    .oMKR_ACK    (mkrAck),
    .oDATA       (rxData),
    .oVALID      (rxValid),
    .iREADY      (rxReady),
    .oBUSY       (busy),
    .oERR_TIMEOUT(errTimeout),
    .iERR_CLR    (errClr),
    .oBYTE_CNT   (byteCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a byte is consumed on the next rising edge when oVALID & iREADY.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rstN && rxValid && rxReady) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none", rxData);
        end else begin
          check("rx_byte", {24'd0, rxData}, {24'd0, expQ.pop_front()});
        end
      end
    end
  end

  // Full four-phase transfer; optionally checks ACK latency against the default 5 +/- 1.
  task automatic sendByte(input logic [7:0] b, input bit chkLat);
    int lat;
    int n;
    @(negedge clk);
    mkrData = b;
    mkrStb  = 1'b1;
    expQ.push_back(b);
    lat = 0;
    while (!mkrAck && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ack_rise", {31'd0, mkrAck}, 32'd1);
    if (chkLat) check("ack_latency_5pm1", {31'd0, (lat >= 4 && lat <= 6)}, 32'd1);
    mkrStb = 1'b0;
    n = 0;
    while (mkrAck && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ack_fall_within_3", {31'd0, (n <= 3)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hi;
    logic sawAck;

    rstN    = 1'b0;
    mkrData = '0;
    mkrStb  = 1'b0;
    rxReady = 1'b0;
    errClr  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack",   {31'd0, mkrAck},     32'd0);
    check("rst_valid", {31'd0, rxValid},    32'd0);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_err",   {31'd0, errTimeout}, 32'd0);
    check("rst_cnt",   {16'd0, byteCnt},    32'd0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Basic transfer with fabric always ready: oVALID is a one-cycle pulse.
    rxReady = 1'b1;
    mkrData = 8'hA5;
    mkrStb  = 1'b1;
    expQ.push_back(8'hA5);
    lat = 0;
    while (!mkrAck && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("basic_ack_latency", lat, 32'd5);
    check("basic_valid_with_ack", {31'd0, rxValid}, 32'd1);
    @(negedge clk);
    check("basic_valid_one_cycle", {31'd0, rxValid}, 32'd0);
    mkrStb = 1'b0;
    hi = 0;
    while (mkrAck && hi < 10) begin
      @(negedge clk);
      hi++;
    end
    check("basic_ack_fall", hi, 32'd3);
    check("basic_cnt", {16'd0, byteCnt}, 32'd1);
    @(negedge clk);

    // Glitch: two high samples are not enough to qualify.
    mkrData = 8'hFF;
    mkrStb  = 1'b1;
    repeat (2) @(negedge clk);
    mkrStb = 1'b0;
    sawAck = 1'b0;
    repeat (8) begin
      @(negedge clk);
      sawAck |= mkrAck | rxValid;
    end
    check("glitch_no_ack", {31'd0, sawAck}, 32'd0);
    check("glitch_idle",   {31'd0, busy},   32'd0);
    check("glitch_cnt",    {16'd0, byteCnt}, 32'd1);

    // Backpressure: second strobe is withheld until fabric frees the buffer.
    rxReady = 1'b0;
    sendByte(8'h11, 1'b1);
    @(negedge clk);
    mkrData = 8'h22;
    mkrStb  = 1'b1;
    expQ.push_back(8'h22);
    sawAck = 1'b0;
    repeat (12) begin
      @(negedge clk);
      sawAck |= mkrAck;
    end
    check("bp_ack_withheld", {31'd0, sawAck},  32'd0);
    check("bp_data_held",    {24'd0, rxData},  32'h11);
    check("bp_busy",         {31'd0, busy},    32'd1);
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
    check("bp_ack_on_release", {31'd0, mkrAck},  32'd1);
    check("bp_valid_stays",    {31'd0, rxValid}, 32'd1);
    check("bp_data_replaced",  {24'd0, rxData},  32'h22);
    mkrStb = 1'b0;
    repeat (4) @(negedge clk);
    check("bp_cnt", {16'd0, byteCnt}, 32'd3);
    rxReady = 1'b1;
    @(negedge clk);

    // Timeout: strobe held for 2000 cycles.
    mkrData = 8'h3C;
    mkrStb  = 1'b1;
    expQ.push_back(8'h3C);
    lat = 0;
    while (!mkrAck && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    hi = 0;
    while (mkrAck && hi < 1100) begin
      @(negedge clk);
      hi++;
    end
    check("to_ack_high_cycles", hi, 32'd1024);
    check("to_err_set", {31'd0, errTimeout}, 32'd1);
    check("to_busy_drain", {31'd0, busy}, 32'd1);
    sawAck = 1'b0;
    repeat (2000 - lat - hi) begin
      @(negedge clk);
      sawAck |= mkrAck | rxValid;
    end
    check("to_no_recapture", {31'd0, sawAck}, 32'd0);
    check("to_cnt", {16'd0, byteCnt}, 32'd4);
    mkrStb = 1'b0;
    repeat (4) @(negedge clk);
    check("to_back_idle", {31'd0, busy}, 32'd0);
    check("to_err_sticky", {31'd0, errTimeout}, 32'd1);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    check("to_err_cleared", {31'd0, errTimeout}, 32'd0);
    sendByte(8'h5A, 1'b1);
    check("after_err_cnt", {16'd0, byteCnt}, 32'd5);

    // Asynchronous reset in the middle of an ACK.
    rxReady = 1'b0;
    @(negedge clk);
    mkrData = 8'h77;
    mkrStb  = 1'b1;
    lat = 0;
    while (!mkrAck && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("mid_ack_high", {31'd0, mkrAck}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    check("mid_rst_ack",   {31'd0, mkrAck},  32'd0);
    check("mid_rst_valid", {31'd0, rxValid}, 32'd0);
    check("mid_rst_cnt",   {16'd0, byteCnt}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy},    32'd0);
    @(negedge clk);
    mkrStb = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Counter wrap from a preloaded value.
    rxReady = 1'b1;
    force dut.oBYTE_CNT = 16'hFFFE;
    #1;
    release dut.oBYTE_CNT;
    sendByte(8'hC3, 1'b1);
    check("wrap_ffff", {16'd0, byteCnt}, 32'h0000FFFF);
    sendByte(8'h3E, 1'b0);
    check("wrap_0000", {16'd0, byteCnt}, 32'h00000000);

    repeat (3) @(negedge clk);
    check("queue_drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
